// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one prescaled down-counting interval timer among N requesters.
// Define TIMER_ARB_ABORT_EN to add the abort input that cancels a running interval.
module timer_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int PRESCALE = 1,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  dur,
`ifdef TIMER_ARB_ABORT_EN
  input  logic            abort,
`endif
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic [W-1:0]    count
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s, run_state_s;
  logic [N-1:0]    gnt_r, gnt_s, done_r;
  logic [ID_W-1:0] gnt_id_r, gnt_id_s, last_r, last_s, win_s;
  logic [W-1:0]    count_r, count_s, run_count_s, win_dur_s;
  logic [PSC_W-1:0] psc_r, psc_s, run_psc_s;
  logic            busy_r, tick_s;

  // First requester at or after last+1, wrapping; returns last when nothing is pending.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] last);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last) + k) % N;
      win   = (!found && r[ID_W'(idx)]) ? ID_W'(idx) : win;
      found = found | r[ID_W'(idx)];
    end
    return win;
  endfunction

  assign win_s     = rr_pick(req, last_r);
  assign win_dur_s = W'(dur >> (int'(win_s) * W));

  // Counting step while running; the 1->0 decrement marks the terminal tick.
  assign tick_s      = (psc_r == PSC_LAST);
  assign run_psc_s   = tick_s ? {PSC_W{1'b0}} : psc_r + PSC_W'(1'b1);
  assign run_count_s = (tick_s && count_r != {W{1'b0}}) ? count_r - W'(1'b1) : count_r;
  assign run_state_s = (tick_s && count_r == W'(1'b1)) ? ST_DONE : ST_RUN;

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    gnt_s    = gnt_r;
    gnt_id_s = gnt_id_r;
    last_s   = last_r;
    count_s  = count_r;
    psc_s    = psc_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          gnt_s    = ONE_N << win_s;
          gnt_id_s = win_s;
          last_s   = win_s;
          count_s  = win_dur_s;
          psc_s    = {PSC_W{1'b0}};
          state_s  = (win_dur_s != {W{1'b0}}) ? ST_RUN : ST_DONE;
        end else begin
          gnt_s = {N{1'b0}};
        end
      end
      ST_RUN: begin
`ifdef TIMER_ARB_ABORT_EN
        // Abort beats a terminal tick landing in the same cycle.
        if (abort) begin
          state_s = ST_IDLE;
          gnt_s   = {N{1'b0}};
          count_s = {W{1'b0}};
          psc_s   = {PSC_W{1'b0}};
        end else begin
          state_s = run_state_s;
          count_s = run_count_s;
          psc_s   = run_psc_s;
        end
`else
        state_s = run_state_s;
        count_s = run_count_s;
        psc_s   = run_psc_s;
`endif
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        gnt_s   = {N{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {N{1'b0}};
      end
    endcase
  end

  // State and registered outputs; done and busy are derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      gnt_r    <= {N{1'b0}};
      gnt_id_r <= {ID_W{1'b0}};
      last_r   <= ID_W'(N - 1);
      count_r  <= {W{1'b0}};
      psc_r    <= {PSC_W{1'b0}};
      done_r   <= {N{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      gnt_r    <= gnt_s;
      gnt_id_r <= gnt_id_s;
      last_r   <= last_s;
      count_r  <= count_s;
      psc_r    <= psc_s;
      done_r   <= (state_s == ST_DONE) ? gnt_s : {N{1'b0}};
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  assign gnt    = gnt_r;
  assign gnt_id = gnt_id_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign count  = count_r;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: instance 0 uses PRESCALE=1, instance 1 uses PRESCALE=3.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         dut;
    int         cyc;
    logic [3:0] vec;
    int         id;
    int         cnt;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_m [2];
  logic [N*W-1:0]  dur_m [2];
  logic [N-1:0]    gnt_m [2];
  logic [N-1:0]    done_m [2];
  logic [1:0]      id_m [2];
  logic            busy_m [2];
  logic [W-1:0]    cnt_m [2];
  logic            abort_a;
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  ev_t             gq[$], dq[$], iq[$], cq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_arbiter #(.N(N), .W(W), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_m[0]), .dur(dur_m[0]),
`ifdef TIMER_ARB_ABORT_EN
    .abort(abort_a),
`endif
    .gnt(gnt_m[0]), .gnt_id(id_m[0]), .done(done_m[0]), .busy(busy_m[0]), .count(cnt_m[0])
  );

  timer_arbiter #(.N(N), .W(W), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_m[1]), .dur(dur_m[1]),
`ifdef TIMER_ARB_ABORT_EN
    .abort(1'b0),
`endif
    .gnt(gnt_m[1]), .gnt_id(id_m[1]), .done(done_m[1]), .busy(busy_m[1]), .count(cnt_m[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int d);
    n_cmp++;
    n_bad++;
    $display("FAIL unexpected_%s: dut %0d at cycle %0d with nothing expected", name, d, cyc);
  endtask

  function automatic void exp_g(input int d, input int cy, input logic [3:0] v, input int id, input int cnt);
    gq.push_back('{d, cy, v, id, cnt});
  endfunction

  function automatic void exp_d(input int d, input int cy, input logic [3:0] v, input int id);
    dq.push_back('{d, cy, v, id, 0});
  endfunction

  function automatic void exp_i(input int d, input int cy);
    iq.push_back('{d, cy, 4'b0000, 0, 0});
  endfunction

  function automatic void exp_c(input int d, input int cy, input int cnt);
    cq.push_back('{d, cy, 4'b0000, 0, cnt});
  endfunction

  // Monitor: grant rise, done pulse, busy fall and scheduled count samples.
  initial begin : monitor
    ev_t        e;
    logic [3:0] pg [2];
    logic       pb [2];
    pg[0] = 4'b0000; pg[1] = 4'b0000; pb[0] = 1'b0; pb[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (gnt_m[d] != 4'b0000 && pg[d] == 4'b0000) begin
          if (gq.size() == 0) unexpected("grant", d);
          else begin
            e = gq.pop_front();
            chk("grant_dut", d, e.dut);
            chk("grant_cycle", cyc, e.cyc);
            chk("grant_vec", int'(gnt_m[d]), int'(e.vec));
            chk("grant_id", int'(id_m[d]), e.id);
            chk("grant_count", int'(cnt_m[d]), e.cnt);
            chk("grant_busy", int'(busy_m[d]), 1);
          end
        end
        if (done_m[d] != 4'b0000) begin
          if (dq.size() == 0) unexpected("done", d);
          else begin
            e = dq.pop_front();
            chk("done_dut", d, e.dut);
            chk("done_cycle", cyc, e.cyc);
            chk("done_vec", int'(done_m[d]), int'(e.vec));
            chk("done_gnt", int'(gnt_m[d]), int'(e.vec));
            chk("done_id", int'(id_m[d]), e.id);
            chk("done_count", int'(cnt_m[d]), 0);
          end
        end
        if (!busy_m[d] && pb[d]) begin
          if (iq.size() == 0) unexpected("idle", d);
          else begin
            e = iq.pop_front();
            chk("idle_dut", d, e.dut);
            chk("idle_cycle", cyc, e.cyc);
            chk("idle_gnt", int'(gnt_m[d]), 0);
            chk("idle_count", int'(cnt_m[d]), 0);
          end
        end
        pg[d] = gnt_m[d];
        pb[d] = busy_m[d];
      end
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        e = cq.pop_front();
        chk("count_step", int'(cnt_m[e.dut]), e.cnt);
      end
    end
  end

  initial begin : stim
    int c;
    req_m[0] = 4'b0000; req_m[1] = 4'b0000;
    dur_m[0] = 32'd0;   dur_m[1] = 32'd0;
    abort_a  = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_gnt", int'(gnt_m[d]), 0);
      chk("reset_done", int'(done_m[d]), 0);
      chk("reset_busy", int'(busy_m[d]), 0);
      chk("reset_count", int'(cnt_m[d]), 0);
      chk("reset_id", int'(id_m[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting, dur=1: grants 0,1,2,3,0 three cycles apart.
    c = cyc;
    req_m[0] = 4'b1111;
    dur_m[0] = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int k = 0; k < 5; k++) begin
      exp_g(0, c + 1 + 3 * k, 4'b0001 << (k % 4), k % 4, 1);
      exp_d(0, c + 2 + 3 * k, 4'b0001 << (k % 4), k % 4);
      exp_i(0, c + 3 + 3 * k);
    end
    repeat (13) @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (4) @(negedge clk);

    // Single requester 0, dur=5.
    c = cyc;
    req_m[0] = 4'b0001;
    dur_m[0] = {8'd0, 8'd0, 8'd0, 8'd5};
    exp_g(0, c + 1, 4'b0001, 0, 5);
    exp_d(0, c + 6, 4'b0001, 0);
    exp_i(0, c + 7);
    @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (8) @(negedge clk);

    // Zero duration: grant and done in the same cycle.
    c = cyc;
    req_m[0] = 4'b0010;
    dur_m[0] = {8'd0, 8'd0, 8'd0, 8'd9};
    exp_g(0, c + 1, 4'b0010, 1, 0);
    exp_d(0, c + 1, 4'b0010, 1);
    exp_i(0, c + 2);
    @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (3) @(negedge clk);

    // req dropped and dur changed mid-run.
    c = cyc;
    req_m[0] = 4'b0100;
    dur_m[0] = {8'd0, 8'd6, 8'd0, 8'd0};
    exp_g(0, c + 1, 4'b0100, 2, 6);
    exp_c(0, c + 3, 4);
    exp_c(0, c + 5, 2);
    exp_d(0, c + 7, 4'b0100, 2);
    exp_i(0, c + 8);
    repeat (3) @(negedge clk);
    req_m[0] = 4'b0000;
    dur_m[0] = {8'd0, 8'd1, 8'd0, 8'd0};
    repeat (6) @(negedge clk);

    // Contention after last=2: 3 wins, then 0 re-requests.
    c = cyc;
    req_m[0] = 4'b1001;
    dur_m[0] = {8'd2, 8'd0, 8'd0, 8'd2};
    exp_g(0, c + 1, 4'b1000, 3, 2);
    exp_d(0, c + 3, 4'b1000, 3);
    exp_i(0, c + 4);
    exp_g(0, c + 5, 4'b0001, 0, 2);
    exp_d(0, c + 7, 4'b0001, 0);
    exp_i(0, c + 8);
    @(negedge clk);
    req_m[0] = 4'b0001;
    repeat (4) @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (4) @(negedge clk);

    // Reset mid-run kills the interval; afterwards index 0 wins over 1 again.
    c = cyc;
    req_m[0] = 4'b0001;
    dur_m[0] = {8'd0, 8'd0, 8'd0, 8'd10};
    exp_g(0, c + 1, 4'b0001, 0, 10);
    @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (3) @(negedge clk);
    exp_i(0, c + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt_m[0]), 0);
    chk("rst_done", int'(done_m[0]), 0);
    chk("rst_busy", int'(busy_m[0]), 0);
    chk("rst_count", int'(cnt_m[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    c = cyc;
    req_m[0] = 4'b0011;
    dur_m[0] = {8'd0, 8'd0, 8'd2, 8'd2};
    exp_g(0, c + 1, 4'b0001, 0, 2);
    exp_d(0, c + 3, 4'b0001, 0);
    exp_i(0, c + 4);
    @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (5) @(negedge clk);

    // PRESCALE=3, dur2=4: count steps every 3 cycles, done 13 cycles after sampling.
    c = cyc;
    req_m[1] = 4'b0100;
    dur_m[1] = {8'd0, 8'd4, 8'd0, 8'd0};
    exp_g(1, c + 1, 4'b0100, 2, 4);
    exp_c(1, c + 4, 3);
    exp_c(1, c + 7, 2);
    exp_c(1, c + 10, 1);
    exp_c(1, c + 12, 1);
    exp_d(1, c + 13, 4'b0100, 2);
    exp_i(1, c + 14);
    @(negedge clk);
    req_m[1] = 4'b0000;
    repeat (15) @(negedge clk);

`ifdef TIMER_ARB_ABORT_EN
    // Abort at count=3, then abort on the terminal tick.
    c = cyc;
    req_m[0] = 4'b0001;
    dur_m[0] = {8'd0, 8'd0, 8'd0, 8'd5};
    exp_g(0, c + 1, 4'b0001, 0, 5);
    exp_c(0, c + 3, 3);
    exp_i(0, c + 4);
    @(negedge clk);
    req_m[0] = 4'b0000;
    repeat (2) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    repeat (2) @(negedge clk);
    c = cyc;
    req_m[0] = 4'b0001;
    dur_m[0] = {8'd0, 8'd0, 8'd0, 8'd2};
    exp_g(0, c + 1, 4'b0001, 0, 2);
    exp_i(0, c + 3);
    @(negedge clk);
    req_m[0] = 4'b0000;
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    repeat (4) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("grant_queue_left", gq.size(), 0);
    chk("done_queue_left", dq.size(), 0);
    chk("idle_queue_left", iq.size(), 0);
    chk("count_queue_left", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
